// File: rtl/dp_seq_pkg.sv
// Shared definitions for the datapath microcode sequencer: instruction
// encodings, field positions, flag indices, FSM states and the no-op
// datapath control pattern. Optional macro: SEQ_SINGLE_STEP_EN (adds PAUSE).
package dp_seq_pkg;

  typedef enum logic [1:0] {
    K_ALU_REG = 2'b00,
    K_ALU_IMM = 2'b01,
    K_BRANCH  = 2'b10,
    K_HALT    = 2'b11
  } kind_e;

`ifdef SEQ_SINGLE_STEP_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALTED,
    S_PAUSE
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALTED
  } state_e;
`endif

  // instruction field low-bit positions
  localparam int KIND_LO    = 30;
  localparam int DST_LO     = 26;
  localparam int SRCA_LO    = 22;
  localparam int SRCB_LO    = 18;
  localparam int OP_LO      = 8;
  localparam int IMM_LO     = 0;
  localparam int BR_INV     = 29;
  localparam int BR_MASK_LO = 24;
  localparam int BR_TGT_LO  = 0;

  // datapath flag indices within flags[4:0]
  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  typedef struct packed {
    logic       select_imm;
    logic [3:0] load_reg;
    logic [3:0] read_a;
    logic [3:0] read_b;
    logic [7:0] imm;
    logic [7:0] op;
  } dp_ctl_t;

  // loadReg=0 means no register write
  localparam dp_ctl_t DP_NOP = '0;

endpackage

// File: rtl/dp_seq_decode.sv
// Combinational decode of one micro-instruction into datapath controls,
// plus branch-taken evaluation against the current datapath flags.
module dp_seq_decode
  import dp_seq_pkg::*;
(
  input  logic [31:0] word,
  input  logic [4:0]  flags,
  output kind_e       kind,
  output dp_ctl_t     ctl,
  output logic        taken,
  output logic [7:0]  target
);

  logic [4:0] mask;
  logic       hit;
  logic       unused_bits;

  // bits [17:16] carry no meaning in any instruction kind
  assign unused_bits = ^word[17:16];

  // field extraction, branch condition and ALU control mapping
  always_comb begin
    kind   = kind_e'(word[KIND_LO +: 2]);
    mask   = word[BR_MASK_LO +: 5];
    target = word[BR_TGT_LO +: 8];
    hit    = (flags[FLAG_C] & mask[FLAG_C]) | (flags[FLAG_L] & mask[FLAG_L]) |
             (flags[FLAG_F] & mask[FLAG_F]) | (flags[FLAG_Z] & mask[FLAG_Z]) |
             (flags[FLAG_N] & mask[FLAG_N]);
    taken  = (kind == K_BRANCH) && (hit ^ word[BR_INV]);
    ctl    = DP_NOP;
    if (kind == K_ALU_REG || kind == K_ALU_IMM) begin
      ctl.select_imm = (kind == K_ALU_IMM);
      ctl.load_reg   = word[DST_LO +: 4];
      ctl.read_a     = word[SRCA_LO +: 4];
      ctl.read_b     = word[SRCB_LO +: 4];
      ctl.op         = word[OP_LO +: 8];
      ctl.imm        = word[IMM_LO +: 8];
    end
  end

endmodule

// File: rtl/dp_sequencer.sv
// Microcode sequencer driving the register-file/ALU datapath controls.
// Fetches from a 1-cycle-latency synchronous program memory, two cycles per
// instruction. Datapath controls are registered, so an instruction's write
// strobe is visible for the single cycle following its EXEC.
// Optional macro: SEQ_SINGLE_STEP_EN (step_mode/step ports, PAUSE state).
//
// state  | meaning
// IDLE   | stopped after reset or abort, waiting for start
// FETCH  | prog_addr holds pc, memory read in flight
// EXEC   | prog_data valid; decode, update pc, count step
// HALTED | HALT executed or watchdog tripped (err); waiting for start
// PAUSE  | single-step hold after EXEC, waiting for step (optional)
module dp_sequencer
  import dp_seq_pkg::*;
#(
  parameter int PC_W       = 8,
  parameter int START_ADDR = 0,
  parameter int MAX_STEPS  = 1023
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic            step_mode,
  input  logic            step,
`endif
  output logic [PC_W-1:0] prog_addr,
  input  logic [31:0]     prog_data,
  input  logic [4:0]      flags,
  output logic            selectImm,
  output logic [3:0]      loadReg,
  output logic [3:0]      readRegA,
  output logic [3:0]      readRegB,
  output logic [7:0]      Imm,
  output logic [7:0]      op,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [PC_W-1:0] pc
);

  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);
  localparam int              STEP_W   = (MAX_STEPS > 0) ? $clog2(MAX_STEPS + 1) : 1;
  localparam logic [STEP_W-1:0] STEP_LOAD = STEP_W'(MAX_STEPS);
  localparam bit              WD_EN    = (MAX_STEPS != 0);

  state_e            state;
  dp_ctl_t           ctl_q;
  logic [STEP_W-1:0] steps_left;

  kind_e             dec_kind;
  dp_ctl_t           dec_ctl;
  logic              dec_taken;
  logic [7:0]        dec_target;
  logic [PC_W-1:0]   pc_next;
  logic              wd_trip;

  dp_seq_decode u_decode (
    .word   (prog_data),
    .flags  (flags),
    .kind   (dec_kind),
    .ctl    (dec_ctl),
    .taken  (dec_taken),
    .target (dec_target)
  );

  // next pc wraps naturally at PC_W bits; watchdog is a down-counter that
  // trips on the instruction that retires with one step remaining
  assign pc_next = dec_taken ? PC_W'(dec_target) : pc + PC_W'(1);
  assign wd_trip = WD_EN && (steps_left == STEP_W'(1));

  assign selectImm = ctl_q.select_imm;
  assign loadReg   = ctl_q.load_reg;
  assign readRegA  = ctl_q.read_a;
  assign readRegB  = ctl_q.read_b;
  assign Imm       = ctl_q.imm;
  assign op        = ctl_q.op;

  // sequencer FSM, pc, watchdog and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      pc         <= START_PC;
      prog_addr  <= START_PC;
      ctl_q      <= DP_NOP;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      steps_left <= STEP_LOAD;
    end else if (abort) begin
      state <= S_IDLE;
      ctl_q <= DP_NOP;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      ctl_q <= DP_NOP;
      case (state)
        S_IDLE, S_HALTED: begin
          if (start) begin
            state      <= S_FETCH;
            pc         <= START_PC;
            prog_addr  <= START_PC;
            steps_left <= STEP_LOAD;
            err        <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end
        S_FETCH: begin
          state <= S_EXEC;
        end
        S_EXEC: begin
          ctl_q <= dec_ctl;
          if (dec_kind == K_HALT) begin
            state <= S_HALTED;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            pc        <= pc_next;
            prog_addr <= pc_next;
            if (wd_trip) begin
              state <= S_HALTED;
              busy  <= 1'b0;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              if (WD_EN) steps_left <= steps_left - STEP_W'(1);
`ifdef SEQ_SINGLE_STEP_EN
              state <= step_mode ? S_PAUSE : S_FETCH;
`else
              state <= S_FETCH;
`endif
            end
          end
        end
`ifdef SEQ_SINGLE_STEP_EN
        S_PAUSE: begin
          if (step) state <= S_FETCH;
        end
`endif
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dp_sequencer.sv
// Directed bench: table-driven single-instruction vectors followed by
// hand-written sequences for reset, watchdog, start/abort races and pc wrap.
module tb_dp_sequencer;

  localparam logic [31:0] HALT = 32'hC000_0000;

  logic        clk;
  logic        reset;
  logic        start_a, abort_a, start_w, abort_w;
  logic [4:0]  flags;

  logic [7:0]  prog_addr_a, pc_a;
  logic [31:0] prog_data_a;
  logic        sel_a, busy_a, done_a, err_a;
  logic [3:0]  ld_a, ra_a, rb_a;
  logic [7:0]  imm_a, op_a;

  logic [3:0]  prog_addr_w, pc_w;
  logic [31:0] prog_data_w;
  logic        sel_w, busy_w, done_w, err_w;
  logic [3:0]  ld_w, ra_w, rb_w;
  logic [7:0]  imm_w, op_w;

  logic [31:0] mem_a [256];
  logic [31:0] mem_w [16];

  int n_checks = 0;
  int n_fail   = 0;

  dp_sequencer #(.PC_W(8), .START_ADDR(0), .MAX_STEPS(3)) u_dut (
    .clk(clk), .reset(reset), .start(start_a), .abort(abort_a),
`ifdef SEQ_SINGLE_STEP_EN
    .step_mode(1'b0), .step(1'b0),
`endif
    .prog_addr(prog_addr_a), .prog_data(prog_data_a), .flags(flags),
    .selectImm(sel_a), .loadReg(ld_a), .readRegA(ra_a), .readRegB(rb_a),
    .Imm(imm_a), .op(op_a), .busy(busy_a), .done(done_a), .err(err_a), .pc(pc_a)
  );

  dp_sequencer #(.PC_W(4), .START_ADDR(15), .MAX_STEPS(0)) u_wrap (
    .clk(clk), .reset(reset), .start(start_w), .abort(abort_w),
`ifdef SEQ_SINGLE_STEP_EN
    .step_mode(1'b0), .step(1'b0),
`endif
    .prog_addr(prog_addr_w), .prog_data(prog_data_w), .flags(flags),
    .selectImm(sel_w), .loadReg(ld_w), .readRegA(ra_w), .readRegB(rb_w),
    .Imm(imm_w), .op(op_w), .busy(busy_w), .done(done_w), .err(err_w), .pc(pc_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    prog_data_a <= mem_a[prog_addr_a];
    prog_data_w <= mem_w[prog_addr_w];
  end

  function automatic logic [31:0] alu_w(input logic [1:0] kind, input logic [3:0] dst,
                                        input logic [3:0] a, input logic [3:0] b,
                                        input logic [7:0] opc, input logic [7:0] imm);
    return {kind, dst, a, b, 2'b00, opc, imm};
  endfunction

  function automatic logic [31:0] br_w(input logic inv, input logic [4:0] mask,
                                       input logic [7:0] tgt);
    return {2'b10, inv, mask, 16'h0000, tgt};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ends at the falling edge after the start edge (sequencer now in FETCH)
  task automatic pulse_start_a();
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
  endtask

  typedef struct {
    logic [31:0] word;
    logic [4:0]  flg;
    logic [28:0] exp_ctl;  // {selectImm, loadReg, readRegA, readRegB, Imm, op}
    logic [7:0]  exp_pc;
  } vec_t;

  vec_t vec [9];

  initial begin
    vec[0] = '{32'h4400_0A05,                           5'b00000, {1'b1, 4'd1, 4'd0,  4'd0,  8'h05, 8'h0A}, 8'h01};
    vec[1] = '{alu_w(2'b00, 4'd3, 4'd5, 4'd9, 8'h21, 8'h7E), 5'b11111, {1'b0, 4'd3, 4'd5,  4'd9,  8'h7E, 8'h21}, 8'h01};
    vec[2] = '{alu_w(2'b01, 4'd0, 4'd15, 4'd15, 8'hFF, 8'hFF), 5'b00000, {1'b1, 4'd0, 4'd15, 4'd15, 8'hFF, 8'hFF}, 8'h01};
    vec[3] = '{br_w(1'b0, 5'b00010, 8'h20),             5'b00010, 29'd0, 8'h20};
    vec[4] = '{br_w(1'b1, 5'b00010, 8'h20),             5'b00010, 29'd0, 8'h01};
    vec[5] = '{br_w(1'b0, 5'b10000, 8'h33),             5'b01111, 29'd0, 8'h01};
    vec[6] = '{br_w(1'b1, 5'b11111, 8'hFF),             5'b00000, 29'd0, 8'hFF};
    vec[7] = '{br_w(1'b0, 5'b00001, 8'h05),             5'b00001, 29'd0, 8'h05};
    vec[8] = '{br_w(1'b0, 5'b01100, 8'h44),             5'b01000, 29'd0, 8'h44};

    for (int i = 0; i < 256; i++) mem_a[i] = HALT;
    for (int i = 0; i < 16; i++)  mem_w[i] = HALT;
    reset = 1'b0; start_a = 1'b0; abort_a = 1'b0; start_w = 1'b0; abort_w = 1'b0;
    flags = 5'b00000;

    // reset state
    @(negedge clk); @(negedge clk);
    chk("reset_a", {busy_a, done_a, err_a, pc_a, prog_addr_a, sel_a, ld_a, ra_a, rb_a, imm_a, op_a}, 64'd0);
    chk("reset_w_pc", {pc_w, prog_addr_w, busy_w, done_w}, {4'hF, 4'hF, 2'b00});
    reset = 1'b1;
    @(negedge clk);

    // single-instruction vectors, each followed by HALT
    for (int i = 0; i < 9; i++) begin
      mem_a[0] = vec[i].word;
      flags    = vec[i].flg;
      pulse_start_a();
      @(negedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_ctl", i), {sel_a, ld_a, ra_a, rb_a, imm_a, op_a}, vec[i].exp_ctl);
      @(negedge clk);
      chk($sformatf("vec%0d_strobe_len", i), {busy_a, ld_a}, {1'b1, 4'd0});
      @(negedge clk);
      chk($sformatf("vec%0d_done", i), {done_a, busy_a, err_a, ld_a}, {3'b100, 4'd0});
      chk($sformatf("vec%0d_pc", i), pc_a, vec[i].exp_pc);
    end

    // asynchronous reset in the middle of an EXEC cycle
    flags    = 5'b00000;
    mem_a[0] = alu_w(2'b01, 4'd1, 4'd0, 4'd0, 8'h0A, 8'h05);
    mem_a[1] = alu_w(2'b00, 4'd2, 4'd3, 4'd4, 8'h01, 8'h02);
    pulse_start_a();
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("pre_reset", {busy_a, pc_a, prog_addr_a}, {1'b1, 8'h01, 8'h01});
    #2 reset = 1'b0;
    #1 chk("async_reset", {busy_a, done_a, err_a, pc_a, prog_addr_a, sel_a, ld_a, imm_a, op_a}, 64'd0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("post_reset_idle", {busy_a, done_a, pc_a}, {2'b00, 8'h00});

    // watchdog: unconditional self-branch trips after the third EXEC
    mem_a[0] = br_w(1'b1, 5'b00000, 8'h00);
    mem_a[1] = HALT;
    pulse_start_a();
    for (int c = 0; c < 5; c++) @(negedge clk);
    chk("wd_before_trip", {busy_a, done_a, err_a}, 3'b100);
    @(negedge clk);
    chk("wd_trip", {busy_a, done_a, err_a, pc_a}, {3'b011, 8'h00});
    pulse_start_a();
    chk("wd_restart_clears_err", {busy_a, done_a, err_a}, 3'b100);
    @(negedge clk); abort_a = 1'b1;
    @(negedge clk); abort_a = 1'b0;
    chk("wd_abort", {busy_a, done_a, err_a}, 3'b000);

    // start during FETCH ignored; abort+start during EXEC -> IDLE, no strobe
    mem_a[0] = alu_w(2'b01, 4'd1, 4'd2, 4'd3, 8'h11, 8'h22);
    mem_a[1] = alu_w(2'b00, 4'd2, 4'd5, 4'd6, 8'h33, 8'h44);
    mem_a[2] = HALT;
    pulse_start_a();
    start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    @(negedge clk);
    chk("start_in_fetch_ignored", {busy_a, ld_a, pc_a}, {1'b1, 4'd1, 8'h01});
    @(negedge clk);
    abort_a = 1'b1; start_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0; start_a = 1'b0;
    chk("abort_suppresses_write", {busy_a, done_a, ld_a}, {2'b00, 4'd0});
    @(negedge clk); @(negedge clk);
    chk("abort_beats_start", {busy_a, done_a, ld_a}, {2'b00, 4'd0});

    // pc wrap on the 4-bit instance starting at 15
    mem_w[15] = alu_w(2'b01, 4'd4, 4'd1, 4'd2, 8'h09, 8'h03);
    mem_w[0]  = HALT;
    @(negedge clk); start_w = 1'b1;
    @(negedge clk); start_w = 1'b0;
    chk("wrap_fetch_addr", {busy_w, prog_addr_w}, {1'b1, 4'hF});
    @(negedge clk); @(negedge clk);
    chk("wrap_next_addr", {prog_addr_w, pc_w, ld_w, sel_w}, {4'h0, 4'h0, 4'd4, 1'b1});
    @(negedge clk); @(negedge clk);
    chk("wrap_done", {done_w, busy_w, pc_w}, {2'b10, 4'h0});

    // watchdog disabled on the wrap instance: self-branch keeps running
    mem_w[15] = br_w(1'b1, 5'b00000, 8'h0F);
    @(negedge clk); start_w = 1'b1;
    @(negedge clk); start_w = 1'b0;
    for (int c = 0; c < 40; c++) @(negedge clk);
    chk("no_watchdog", {busy_w, done_w, err_w, pc_w}, {3'b100, 4'hF});
    abort_w = 1'b1;
    @(negedge clk); abort_w = 1'b0;
    chk("wrap_abort", {busy_w, done_w}, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dp_sequencer.md
Name: dp_sequencer

Overview:
- Microcode sequencer for the register-file/ALU datapath; replaces the hand-coded FSM as the source of selectImm, loadReg, readRegA, readRegB, Imm and op.
- Fetches 32-bit micro-instructions from an external synchronous program memory (1-cycle read latency), executes ALU, branch and halt instructions, and reports busy/done/err to the top level.

Parameters:
- PC_W, 8, program counter / program address width.
- START_ADDR, 0, PC value loaded on start.
- MAX_STEPS, 1023, retired-instruction limit before watchdog abort; 0 disables the watchdog.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a program run from IDLE or HALTED.
- abort  in  1  forces return to IDLE.
- prog_addr  out  PC_W  program memory address (registered).
- prog_data  in  32  program word, valid the cycle after prog_addr.
- flags  in  5  datapath flags {C,L,F,Z,N} = [4:0].
- selectImm  out  1  1 = B operand is Imm.
- loadReg  out  4  destination register index; 4'd0 = no write (r0 not writable).
- readRegA  out  4  A operand register index.
- readRegB  out  4  B operand register index.
- Imm  out  8  immediate operand.
- op  out  8  ALU opcode, passed through from the instruction.
- busy  out  1  high in FETCH/EXEC.
- done  out  1  high while in HALTED.
- err  out  1  high while in HALTED after a watchdog trip; cleared by start.
- pc  out  PC_W  current PC, for debug/SSD display.

Behaviour:
- Instruction word: [31:30] kind (00 ALU_REG, 01 ALU_IMM, 10 BRANCH, 11 HALT).
  - ALU: [29:26] dst, [25:22] srcA, [21:18] srcB, [15:8] op, [7:0] imm.
  - BRANCH: [29] invert, [28:24] flag mask, [7:0] target; only target[PC_W-1:0] is used.
- States: IDLE, FETCH, EXEC, HALTED. All outputs are registered.
- Reset (async, reset=0): state IDLE, pc=START_ADDR, prog_addr=START_ADDR, all datapath outputs 0, busy=0, done=0, err=0, step count 0.
- IDLE/HALTED + start: pc<=START_ADDR, step count cleared, err<=0, go to FETCH.
- FETCH (1 cycle): prog_addr=pc; datapath outputs driven to the no-op pattern (loadReg=0). Next state EXEC.
- EXEC (1 cycle): decode prog_data.
  - ALU_REG: drive loadReg=dst, readRegA=srcA, readRegB=srcB, op, selectImm=0, Imm=imm, for exactly this one cycle (write strobe). pc<=pc+1.
  - ALU_IMM: as ALU_REG but selectImm=1.
  - BRANCH: taken = ((flags & mask)!=0) XOR invert; pc<=taken ? target : pc+1. loadReg=0. flags are sampled in this EXEC cycle; they reflect the previous ALU write.
  - HALT: pc unchanged; go to HALTED, done=1.
  - After a non-HALT instruction go to FETCH. Throughput is 2 cycles per instruction.
- PC wraps modulo 2^PC_W (all-ones + 1 = 0).
- Watchdog: step count increments per retired instruction. When it reaches MAX_STEPS (MAX_STEPS != 0), go to HALTED with err=1 and done=1 after that instruction's EXEC.
- start while busy: ignored.
- abort (any state, highest priority after reset): next state IDLE, loadReg=0, busy=0, done=0. An in-flight EXEC write in the same cycle is suppressed.
- start and abort in the same cycle: abort wins.

Optional Feature:
- Macro SEQ_SINGLE_STEP_EN.
- Defined: adds input step_mode (1) and step (1-cycle pulse), plus state PAUSE. With step_mode=1, every EXEC goes to PAUSE instead of FETCH. PAUSE holds outputs in the no-op pattern with busy=1 and advances to FETCH on step. abort and watchdog rules are unchanged.
- Not defined: no ports, no PAUSE state; runs free.

Decomposition:
- Package dp_seq_pkg holds:
  - kind encodings and state enum;
  - instruction field bit positions;
  - flag index constants (FLAG_C=4, FLAG_L=3, FLAG_F=2, FLAG_Z=1, FLAG_N=0);
  - the NOP datapath output pattern.
- One sub-module: dp_seq_decode, a combinational instruction-word-to-datapath-control decoder plus branch-taken evaluation. The state machine, PC and watchdog stay in dp_sequencer.

Test Plan:
- Reset: reset=0 mid-EXEC -> all outputs 0 and state IDLE asynchronously; pc=0 after release.
- ALU_IMM: word 0x4400_0A05 (dst=1, op=0x0A, imm=5) then HALT, start -> EXEC cycle shows loadReg=1, selectImm=1, Imm=5, op=0x0A for exactly 1 cycle; done=1 on the 4th cycle after start.
- Branch: flags=5'b00010 (Z), BRANCH mask=00010 target=0x20 -> pc=0x20; with invert=1 -> pc=old+1.
- PC wrap: PC_W=4, START_ADDR=15, word at 15 is ALU -> next prog_addr=0.
- Watchdog: MAX_STEPS=3, program of unconditional self-branch at 0 (mask=0, invert=1) -> HALTED, err=1 and done=1 after the 3rd EXEC; a subsequent start clears err.
- Abort/start race: start at FETCH is ignored; abort asserted together with start in EXEC -> IDLE, no write strobe that cycle (loadReg=0).
